// File: rtl/pfb_coeff_reload_packer.sv
// Unpacks host words of two signed 16-bit taps into scaled 32-bit coefficient beats,
// forcing every reload frame to exactly NUM_COEFFS beats by zero-padding or draining.
module pfb_coeff_reload_packer #(
    parameter int NUM_COEFFS = 65536,
    parameter int GAIN_SHIFT = 0
) (
    input  logic        clk,
    input  logic        sync_reset,
    input  logic        s_axis_coef_tvalid,
    input  logic [31:0] s_axis_coef_tdata,
    input  logic        s_axis_coef_tlast,
    output logic        s_axis_coef_tready,
    output logic        m_axis_reload_tvalid,
    output logic [31:0] m_axis_reload_tdata,
    output logic        m_axis_reload_tlast,
    input  logic        m_axis_reload_tready,
    output logic        underflow_err,
    output logic        overflow_err,
    output logic        frame_done
);
    typedef enum logic [1:0] {S_LOAD, S_PAD, S_DRAIN, S_WAIT} state_t;

    localparam logic [16:0] LAST_IDX = 17'(NUM_COEFFS - 1);
    localparam logic [16:0] FULL_CNT = 17'(NUM_COEFFS);

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic        word_last_q, word_last_d;
    logic        word_valid_q, word_valid_d;
    logic        half_q, half_d;
    logic [16:0] load_cnt_q, load_cnt_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic        out_valid_q, out_valid_d;
    logic        underflow_q, underflow_d;
    logic        overflow_q, overflow_d;
    logic        frame_done_q, frame_done_d;
    logic        tail_seen_q, tail_seen_d;

    logic        take;
    logic        out_free;
    logic        last_accept;
    logic [15:0] tap;
    logic [31:0] tap_scaled;
    logic [16:0] cnt_inc;
    logic        at_last;

    assign s_axis_coef_tready = ((state_q == S_LOAD) && !word_valid_q) || (state_q == S_DRAIN);

    assign take        = s_axis_coef_tvalid && s_axis_coef_tready;
    assign out_free    = !out_valid_q || m_axis_reload_tready;
    assign last_accept = out_valid_q && out_last_q && m_axis_reload_tready;
    assign tap         = half_q ? word_q[31:16] : word_q[15:0];
    assign tap_scaled  = {{16{tap[15]}}, tap} << GAIN_SHIFT;
    assign cnt_inc     = load_cnt_q + 17'd1;
    assign at_last     = (load_cnt_q == LAST_IDX);

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        word_last_d  = word_last_q;
        word_valid_d = word_valid_q;
        half_d       = half_q;
        load_cnt_d   = load_cnt_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;
        underflow_d  = underflow_q;
        overflow_d   = overflow_q;
        frame_done_d = last_accept;
        tail_seen_d  = tail_seen_q;

        if (out_valid_q && m_axis_reload_tready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            S_LOAD: begin
                if (take) begin
                    word_d       = s_axis_coef_tdata;
                    word_last_d  = s_axis_coef_tlast;
                    word_valid_d = 1'b1;
                    half_d       = 1'b0;
                    // load_cnt is zero only before the first beat, so this is the frame's first word
                    if (load_cnt_q == 17'd0) begin
                        underflow_d = 1'b0;
                        overflow_d  = 1'b0;
                    end
                end
                if (word_valid_q && out_free) begin
                    out_data_d  = tap_scaled;
                    out_last_d  = at_last;
                    out_valid_d = 1'b1;
                    load_cnt_d  = cnt_inc;
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        word_valid_d = 1'b0;
                    end
                    if (cnt_inc == FULL_CNT) begin
                        word_valid_d = 1'b0;
                        if (half_q && word_last_q) begin
                            state_d = S_WAIT;
                        end else begin
                            state_d     = S_DRAIN;
                            overflow_d  = 1'b1;
                            tail_seen_d = 1'b0;
                        end
                    end else if (half_q && word_last_q) begin
                        state_d     = S_PAD;
                        underflow_d = 1'b1;
                    end
                end
            end
            S_PAD: begin
                if (out_free) begin
                    out_data_d  = 32'd0;
                    out_last_d  = at_last;
                    out_valid_d = 1'b1;
                    load_cnt_d  = cnt_inc;
                    if (cnt_inc == FULL_CNT) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_DRAIN: begin
                // The tlast beat may leave before the host's last word shows up
                if (last_accept) begin
                    tail_seen_d = 1'b1;
                end
                if (take && s_axis_coef_tlast) begin
                    if (tail_seen_q || last_accept) begin
                        state_d     = S_LOAD;
                        load_cnt_d  = 17'd0;
                        tail_seen_d = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (last_accept) begin
                    state_d    = S_LOAD;
                    load_cnt_d = 17'd0;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            state_q      <= S_LOAD;
            word_q       <= 32'd0;
            word_last_q  <= 1'b0;
            word_valid_q <= 1'b0;
            half_q       <= 1'b0;
            load_cnt_q   <= 17'd0;
            out_data_q   <= 32'd0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            underflow_q  <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            tail_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            word_last_q  <= word_last_d;
            word_valid_q <= word_valid_d;
            half_q       <= half_d;
            load_cnt_q   <= load_cnt_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            underflow_q  <= underflow_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
            tail_seen_q  <= tail_seen_d;
        end
    end

    assign m_axis_reload_tvalid = out_valid_q;
    assign m_axis_reload_tdata  = out_data_q;
    assign m_axis_reload_tlast  = out_last_q;
    assign underflow_err        = underflow_q;
    assign overflow_err         = overflow_q;
    assign frame_done           = frame_done_q;
endmodule

// File: tb/tb_pfb_coeff_reload_packer.sv
// Bench for pfb_coeff_reload_packer: random host frames and sink stalls, beats compared
// against a frame-level reference (truncate/pad the tap list, scale by multiplication).
module tb_pfb_coeff_reload_packer;
    localparam int NC = 8;
    localparam int GS = 9;

    logic        clk = 1'b0;
    logic        syncReset = 1'b1;
    logic        sValid, sLast, sReady;
    logic [31:0] sData;
    logic        mValid, mLast, mReady;
    logic [31:0] mData;
    logic        underflowErr, overflowErr, frameDone;

    int compared = 0;
    int mismatched = 0;
    logic [32:0] beatsQ[$];
    logic [15:0] frameTaps[$];
    int doneCount = 0;
    int readyMode = 0;
    bit stallPend = 1'b0;
    logic [31:0] stallData;
    logic stallLast;

    pfb_coeff_reload_packer #(.NUM_COEFFS(NC), .GAIN_SHIFT(GS)) dut (
        .clk                  (clk),
        .sync_reset           (syncReset),
        .s_axis_coef_tvalid   (sValid),
        .s_axis_coef_tdata    (sData),
        .s_axis_coef_tlast    (sLast),
        .s_axis_coef_tready   (sReady),
        .m_axis_reload_tvalid (mValid),
        .m_axis_reload_tdata  (mData),
        .m_axis_reload_tlast  (mLast),
        .m_axis_reload_tready (mReady),
        .underflow_err        (underflowErr),
        .overflow_err         (overflowErr),
        .frame_done           (frameDone)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] refScale(input logic [15:0] t);
        int v;
        v = int'($signed(t)) * (1 << GS);
        return 32'(v);
    endfunction

    // Sink: picks tready for the coming edge, records handshakes, watches stall stability
    initial begin
        mReady = 1'b0;
        forever begin
            @(negedge clk);
            mReady = (readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (syncReset) begin
                stallPend = 1'b0;
            end else begin
                if (stallPend) begin
                    checkOutput("stall_valid", 32'(mValid), 32'd1);
                    checkOutput("stall_data", mData, stallData);
                    checkOutput("stall_last", 32'(mLast), 32'(stallLast));
                end
                if (mValid && mReady) beatsQ.push_back({mLast, mData});
                stallPend = mValid && !mReady;
                stallData = mData;
                stallLast = mLast;
                if (frameDone) doneCount++;
            end
        end
    end

    // Must be called just after a rising edge; returns just after the edge that took the word
    task automatic applyStimulus(input logic [31:0] w, input logic last);
        int waited = 0;
        sValid = 1'b1;
        sData  = w;
        sLast  = last;
        do begin
            @(negedge clk);
            waited++;
        end while (!sReady && waited < 1000);
        checkOutput("host_accept", 32'(sReady), 32'd1);
        @(posedge clk);
        #1;
        sValid = 1'b0;
    endtask

    task automatic runFrame(input int gapMax, input int mode, input string name);
        int numWords = frameTaps.size() / 2;
        int startDone;
        int waited = 0;
        logic [31:0] expData;
        logic [32:0] beat;
        bit expUnder = frameTaps.size() < NC;
        bit expOver  = frameTaps.size() > NC;
        readyMode = mode;
        @(posedge clk);
        #1;
        beatsQ.delete();
        startDone = doneCount;
        for (int i = 0; i < numWords; i++) begin
            applyStimulus({frameTaps[2*i+1], frameTaps[2*i]}, i == numWords - 1);
            if (i == 0) begin
                checkOutput({name, "_under_clr"}, 32'(underflowErr), 32'd0);
                checkOutput({name, "_over_clr"}, 32'(overflowErr), 32'd0);
            end
            repeat ($urandom_range(0, gapMax)) begin
                @(posedge clk);
                #1;
            end
        end
        while ((beatsQ.size() < NC || doneCount == startDone) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        checkOutput({name, "_beats"}, 32'(beatsQ.size()), 32'(NC));
        checkOutput({name, "_done"}, 32'(doneCount - startDone), 32'd1);
        for (int i = 0; i < NC; i++) begin
            expData = (i < frameTaps.size()) ? refScale(frameTaps[i]) : 32'd0;
            if (i < beatsQ.size()) begin
                beat = beatsQ[i];
                checkOutput($sformatf("%s_data%0d", name, i), beat[31:0], expData);
                checkOutput($sformatf("%s_last%0d", name, i), 32'(beat[32]), 32'(i == NC - 1));
            end
        end
        checkOutput({name, "_underflow"}, 32'(underflowErr), 32'(expUnder));
        checkOutput({name, "_overflow"}, 32'(overflowErr), 32'(expOver));
    endtask

    task automatic fillRamp(input int count, input int base);
        frameTaps.delete();
        for (int i = 0; i < count; i++) frameTaps.push_back(16'(base + i));
    endtask

    initial begin
        int nw;
        sValid = 1'b0;
        sData  = 32'd0;
        sLast  = 1'b0;
        syncReset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_tvalid", 32'(mValid), 32'd0);
        checkOutput("rst_tdata", mData, 32'd0);
        checkOutput("rst_flags", {29'd0, underflowErr, overflowErr, frameDone}, 32'd0);
        #2 syncReset = 1'b0;
        @(posedge clk);
        #1;

        // Latency: word taken in cycle N, low tap at N+2, high tap at N+3
        readyMode = 0;
        sValid = 1'b1;
        sData  = 32'h8000_0001;
        sLast  = 1'b0;
        @(negedge clk);
        checkOutput("lat_tready", 32'(sReady), 32'd1);
        @(posedge clk);
        #1;
        sValid = 1'b0;
        @(negedge clk);
        checkOutput("lat_n1_valid", 32'(mValid), 32'd0);
        @(negedge clk);
        checkOutput("lat_n2_valid", 32'(mValid), 32'd1);
        checkOutput("lat_n2_data", mData, 32'h0000_0200);
        @(negedge clk);
        checkOutput("lat_n3_data", mData, 32'hFF00_0000);
        checkOutput("lat_n3_mask", mData & 32'h01FF_FFFF, 32'h0100_0000);

        // Mid-frame reset with more beats in flight
        @(posedge clk);
        #1;
        applyStimulus(32'h0004_0003, 1'b0);
        @(negedge clk);
        #2 syncReset = 1'b1;
        #1;
        checkOutput("mrst_tvalid", 32'(mValid), 32'd0);
        checkOutput("mrst_tdata", mData, 32'd0);
        checkOutput("mrst_tlast", 32'(mLast), 32'd0);
        repeat (2) @(negedge clk);
        #2 syncReset = 1'b0;

        fillRamp(NC, 16'h0100);
        runFrame(0, 0, "post_rst");

        frameTaps.delete();
        for (int i = 1; i <= 4; i++) frameTaps.push_back(16'(i));
        runFrame(0, 0, "short");

        fillRamp(12, 16'h0010);
        runFrame(0, 0, "long");
        fillRamp(12, 16'h0030);
        runFrame(6, 0, "long_slow");
        fillRamp(NC, 16'hFFFC);
        runFrame(0, 0, "clean");

        frameTaps.delete();
        frameTaps.push_back(16'h8000);
        frameTaps.push_back(16'h0001);
        frameTaps.push_back(16'h7FFF);
        frameTaps.push_back(16'hFFFF);
        runFrame(1, 1, "scale");

        for (int f = 0; f < 24; f++) begin
            nw = $urandom_range(1, 7);
            frameTaps.delete();
            for (int i = 0; i < 2 * nw; i++) frameTaps.push_back(16'($urandom));
            runFrame(0, 0, $sformatf("rnd%0d_free", f));
            runFrame($urandom_range(0, 2), 1, $sformatf("rnd%0d_bp", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
